// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction sequencer: FSM states,
// opcode and condition encodings, and instruction field positions.
package isa_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  // Opcodes with special sequencing; every other opcode is data-processing.
  localparam logic [3:0] OP_LDR  = 4'hA;
  localparam logic [3:0] OP_STR  = 4'hB;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Condition codes come in pairs: cond[3:1] picks the base test and
  // cond[0] inverts it (EQ/NE, CS/CC, ... , AL/NV).
  localparam logic [2:0] CPAIR_Z   = 3'd0;  // EQ / NE
  localparam logic [2:0] CPAIR_C   = 3'd1;  // CS / CC
  localparam logic [2:0] CPAIR_N   = 3'd2;  // MI / PL
  localparam logic [2:0] CPAIR_V   = 3'd3;  // VS / VC
  localparam logic [2:0] CPAIR_HI  = 3'd4;  // HI / LS
  localparam logic [2:0] CPAIR_GE  = 3'd5;  // GE / LT
  localparam logic [2:0] CPAIR_GT  = 3'd6;  // GT / LE
  localparam logic [2:0] CPAIR_AL  = 3'd7;  // AL / NV

  // Instruction field bit positions.
  localparam int COND_MSB = 31;
  localparam int COND_LSB = 28;
  localparam int OP_MSB   = 27;
  localparam int OP_LSB   = 24;
  localparam int SBIT_POS = 23;
  localparam int TGT_MSB  = 10;
  localparam int TGT_LSB  = 3;

  function automatic logic is_dataproc(input logic [3:0] op);
    return !(op inside {OP_B, OP_LDR, OP_STR, OP_HALT});
  endfunction

endpackage

// File: rtl/instr_sequencer_cond_eval.sv
// Combinational condition evaluator: {cond, NZCV} -> pass.
module cond_eval
  import isa_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;
  logic base;

  assign n = flags_i[3];
  assign z = flags_i[2];
  assign c = flags_i[1];
  assign v = flags_i[0];

  // Base test selected by the condition pair, inverted by the low bit.
  always_comb begin
    base = 1'b1;
    case (cond_i[3:1])
      CPAIR_Z:  base = z;
      CPAIR_C:  base = c;
      CPAIR_N:  base = n;
      CPAIR_V:  base = v;
      CPAIR_HI: base = c & ~z;
      CPAIR_GE: base = (n == v);
      CPAIR_GT: base = ~z & (n == v);
      CPAIR_AL: base = 1'b1;
      default:  base = 1'b1;
    endcase
    pass_o = cond_i[0] ? ~base : base;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/commit sequencer: owns the PC, latches the current
// instruction for the datapath and issues one-cycle write strobes.
module instr_sequencer
  import isa_pkg::*;
#(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [PC_WIDTH-1:0]    fetch_addr,
  input  logic [INSTR_WIDTH-1:0] fetch_data,
  output logic [INSTR_WIDTH-1:0] instr,
  input  logic [3:0]             flags,
  output logic                   reg_we,
  output logic                   flag_we,
  output logic                   mem_req,
  output logic                   mem_rw,
  input  logic                   mem_ready,
  output logic                   halted,
  output logic [15:0]            retired
);

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d, pc_inc, br_target;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [15:0]            retired_q, retired_d;
  logic [3:0]             cond, op;
  logic                   s_bit, cond_pass, dp_op, exec_go;
  logic [14:0]            unused_instr_bits;

  assign cond      = instr_q[COND_MSB:COND_LSB];
  assign op        = instr_q[OP_MSB:OP_LSB];
  assign s_bit     = instr_q[SBIT_POS];
  assign br_target = PC_WIDTH'(instr_q[TGT_MSB:TGT_LSB]);
  assign pc_inc    = pc_q + PC_WIDTH'(1);
  assign dp_op     = is_dataproc(op);
  assign exec_go   = (state_q == ST_EXEC) && cond_pass;

  // Fields not used by the sequencer itself; they go to the datapath via instr.
  assign unused_instr_bits = {instr_q[22:11], instr_q[2:0]};

  cond_eval u_cond_eval (
    .cond_i  (cond),
    .flags_i (flags),
    .pass_o  (cond_pass)
  );

  // Next-state, PC, instruction latch and retire-count decode.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        instr_d = fetch_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (!cond_pass) begin
          pc_d = pc_inc;
        end else begin
          case (op)
            OP_B:           pc_d = br_target;
            OP_LDR, OP_STR: state_d = ST_MEM;
            OP_HALT:        state_d = ST_HALT;
            default:        pc_d = pc_inc;
          endcase
          // Memory ops retire when the access completes, not here.
          if (op != OP_LDR && op != OP_STR) retired_d = retired_q + 16'd1;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          pc_d      = pc_inc;
          state_d   = ST_FETCH;
          retired_d = retired_q + 16'd1;
        end
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Strobes decode the registered state; LDR write-back lands on the ready cycle.
  assign reg_we     = (exec_go && dp_op) ||
                      ((state_q == ST_MEM) && mem_ready && (op == OP_LDR));
  assign flag_we    = exec_go && dp_op && s_bit;
  assign mem_req    = (state_q == ST_MEM);
  assign mem_rw     = (state_q == ST_MEM) && (op == OP_STR);
  assign halted     = (state_q == ST_HALT);
  assign fetch_addr = pc_q;
  assign instr      = instr_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer with a scoreboard of per-instruction expectations.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  fetch_addr;
  logic [31:0] fetch_data = '0;
  logic [31:0] instr;
  logic [3:0]  flags = '0;
  logic        reg_we, flag_we, mem_req, mem_rw;
  logic        mem_ready = 1'b0;
  logic        halted;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    int          cycles;
    logic [31:0] reg_m, flag_m, req_m;
    logic        rw_bad;
    logic [7:0]  pc_first, pc_after;
    logic [15:0] ret_after;
    logic        halted_after;
    logic [31:0] instr3;
  } rec_t;

  rec_t        exp_q[$];
  logic [7:0]  exp_pc = '0;
  logic [15:0] exp_ret = '0;
  logic [31:0] ram [256];

  always #5 clk = ~clk;

  // Fetch port RAM model: one-cycle read latency.
  always @(posedge clk) fetch_data <= ram[fetch_addr];

  instr_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .instr      (instr),
    .flags      (flags),
    .reg_we     (reg_we),
    .flag_we    (flag_we),
    .mem_req    (mem_req),
    .mem_rw     (mem_rw),
    .mem_ready  (mem_ready),
    .halted     (halted),
    .retired    (retired)
  );

  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Place one instruction at the expected PC, push its expectation, and
  // observe the DUT for the expected number of cycles. Starts and ends at
  // the negedge inside a FETCH cycle. Flags are inverted outside EXEC and
  // mem_ready is high outside MEM, both of which must be ignored.
  task automatic run_instr(input string name, input logic [31:0] word,
                           input logic [3:0] fl, input int n_mem, output rec_t obs);
    rec_t e;
    logic [3:0] op;
    op = word[27:24];
    e.name = name; e.cycles = 3; e.reg_m = '0; e.flag_m = '0; e.req_m = '0;
    e.rw_bad = 1'b0; e.pc_first = exp_pc; e.instr3 = word; e.halted_after = 1'b0;
    if (cond_model(word[31:28], fl)) begin
      exp_ret = exp_ret + 16'd1;
      case (op)
        4'hC: exp_pc = word[10:3];
        4'hA, 4'hB: begin
          e.cycles = 3 + n_mem;
          for (int c = 4; c <= e.cycles; c++) e.req_m[c] = 1'b1;
          if (op == 4'hA) e.reg_m[e.cycles] = 1'b1;
          exp_pc = exp_pc + 8'd1;
        end
        4'hF: e.halted_after = 1'b1;
        default: begin
          e.reg_m[3] = 1'b1;
          e.flag_m[3] = word[23];
          exp_pc = exp_pc + 8'd1;
        end
      endcase
    end else begin
      exp_pc = exp_pc + 8'd1;
    end
    e.pc_after = exp_pc;
    e.ret_after = exp_ret;
    exp_q.push_back(e);
    ram[e.pc_first] = word;

    obs.name = name; obs.cycles = e.cycles; obs.reg_m = '0; obs.flag_m = '0;
    obs.req_m = '0; obs.rw_bad = 1'b0; obs.pc_first = 'x; obs.instr3 = 'x;
    for (int c = 1; c <= e.cycles; c++) begin
      flags = (c == 3) ? fl : ~fl;
      mem_ready = (c < 4) || (c == e.cycles);
      #1;
      if (c == 1) obs.pc_first = fetch_addr;
      if (c == 3) obs.instr3 = instr;
      obs.reg_m[c] = reg_we;
      obs.flag_m[c] = flag_we;
      obs.req_m[c] = mem_req;
      if (mem_req && (mem_rw !== (op == 4'hB))) obs.rw_bad = 1'b1;
      @(negedge clk);
    end
    obs.pc_after = fetch_addr;
    obs.ret_after = retired;
    obs.halted_after = halted;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b0; flags = '0;
    for (int i = 0; i < 256; i++) ram[i] = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (fetch_addr !== 8'h00) begin errors++; $display("FAIL reset fetch_addr got %h want 00", fetch_addr); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset instr got %h want 0", instr); end
    checks++; if ({reg_we, flag_we, mem_req} !== 3'b000) begin errors++; $display("FAIL reset strobes got %b want 000", {reg_we, flag_we, mem_req}); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset halted got %b want 0", halted); end
    checks++; if (retired !== 16'h0) begin errors++; $display("FAIL reset retired got %0d want 0", retired); end
    reset = 1'b0;
    exp_pc = 8'h00; exp_ret = 16'h0;
    $display("reset: fetch_addr=%h retired=%0d", fetch_addr, retired);
  endtask

  task automatic test_dataproc();
    rec_t o, e;
    run_instr("al_add_s", 32'hE180_0000, 4'b0000, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.pc_first !== e.pc_first) begin errors++; $display("FAIL %s fetch_addr got %h want %h", e.name, o.pc_first, e.pc_first); end
    checks++; if (o.instr3 !== e.instr3) begin errors++; $display("FAIL %s instr got %h want %h", e.name, o.instr3, e.instr3); end
    checks++; if (o.reg_m !== e.reg_m) begin errors++; $display("FAIL %s reg_we cycles got %b want %b", e.name, o.reg_m, e.reg_m); end
    checks++; if (o.flag_m !== e.flag_m) begin errors++; $display("FAIL %s flag_we cycles got %b want %b", e.name, o.flag_m, e.flag_m); end
    checks++; if (o.req_m !== e.req_m) begin errors++; $display("FAIL %s mem_req cycles got %b want %b", e.name, o.req_m, e.req_m); end
    checks++; if (o.pc_after !== e.pc_after) begin errors++; $display("FAIL %s pc got %h want %h", e.name, o.pc_after, e.pc_after); end
    checks++; if (o.ret_after !== e.ret_after) begin errors++; $display("FAIL %s retired got %0d want %0d", e.name, o.ret_after, e.ret_after); end
    $display("%s: pc=%h retired=%0d reg_we=%b flag_we=%b", o.name, o.pc_after, o.ret_after, o.reg_m, o.flag_m);
  endtask

  task automatic test_cond_eq();
    rec_t o, e;
    logic [3:0] fl [2];
    fl[0] = 4'b0000; fl[1] = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      run_instr(i == 0 ? "eq_z0" : "eq_z1", 32'h0280_0000, fl[i], 0, o);
      e = exp_q.pop_front();
      checks++; if (o.reg_m !== e.reg_m) begin errors++; $display("FAIL %s reg_we cycles got %b want %b", e.name, o.reg_m, e.reg_m); end
      checks++; if (o.flag_m !== e.flag_m) begin errors++; $display("FAIL %s flag_we cycles got %b want %b", e.name, o.flag_m, e.flag_m); end
      checks++; if (o.pc_after !== e.pc_after) begin errors++; $display("FAIL %s pc got %h want %h", e.name, o.pc_after, e.pc_after); end
      checks++; if (o.ret_after !== e.ret_after) begin errors++; $display("FAIL %s retired got %0d want %0d", e.name, o.ret_after, e.ret_after); end
      $display("%s: pc=%h retired=%0d reg_we=%b", o.name, o.pc_after, o.ret_after, o.reg_m);
    end
  endtask

  task automatic test_branch();
    rec_t o, e;
    logic [31:0] words [2];
    words[0] = 32'hEC00_0080;  // B 0x10
    words[1] = 32'hEC00_0200;  // B 0x40 from 0x10
    for (int i = 0; i < 2; i++) begin
      run_instr(i == 0 ? "b_10" : "b_40", words[i], 4'b0000, 0, o);
      e = exp_q.pop_front();
      checks++; if (o.pc_first !== e.pc_first) begin errors++; $display("FAIL %s fetch_addr got %h want %h", e.name, o.pc_first, e.pc_first); end
      checks++; if (o.pc_after !== e.pc_after) begin errors++; $display("FAIL %s pc got %h want %h", e.name, o.pc_after, e.pc_after); end
      checks++; if ((o.reg_m | o.flag_m | o.req_m) !== 32'h0) begin errors++; $display("FAIL %s strobes got %b want 0", e.name, o.reg_m | o.flag_m | o.req_m); end
      checks++; if (o.ret_after !== e.ret_after) begin errors++; $display("FAIL %s retired got %0d want %0d", e.name, o.ret_after, e.ret_after); end
      $display("%s: from=%h pc=%h retired=%0d", o.name, o.pc_first, o.pc_after, o.ret_after);
    end
  endtask

  task automatic test_pc_wrap();
    rec_t o, e;
    run_instr("b_ff", 32'hEC00_07F8, 4'b0000, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.pc_after !== e.pc_after) begin errors++; $display("FAIL %s pc got %h want %h", e.name, o.pc_after, e.pc_after); end
    $display("%s: pc=%h", o.name, o.pc_after);
    run_instr("wrap_dp", 32'hE300_0000, 4'b0000, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.pc_first !== e.pc_first) begin errors++; $display("FAIL %s fetch_addr got %h want %h", e.name, o.pc_first, e.pc_first); end
    checks++; if (o.pc_after !== e.pc_after) begin errors++; $display("FAIL %s pc got %h want %h", e.name, o.pc_after, e.pc_after); end
    checks++; if (o.reg_m !== e.reg_m) begin errors++; $display("FAIL %s reg_we cycles got %b want %b", e.name, o.reg_m, e.reg_m); end
    $display("%s: from=%h pc=%h", o.name, o.pc_first, o.pc_after);
  endtask

  task automatic test_ldr_str();
    rec_t o, e;
    logic [31:0] words [3];
    logic [3:0]  fls [3];
    int          ns [3];
    words[0] = 32'hEA00_0000; fls[0] = 4'b0000; ns[0] = 5;  // LDR, ready low 4 cycles
    words[1] = 32'hEB00_0000; fls[1] = 4'b0000; ns[1] = 2;  // STR
    words[2] = 32'h1A00_0000; fls[2] = 4'b0100; ns[2] = 1;  // NE LDR, fails
    for (int i = 0; i < 3; i++) begin
      run_instr(i == 0 ? "ldr" : (i == 1 ? "str" : "ldr_ne_fail"), words[i], fls[i], ns[i], o);
      e = exp_q.pop_front();
      checks++; if (o.req_m !== e.req_m) begin errors++; $display("FAIL %s mem_req cycles got %b want %b", e.name, o.req_m, e.req_m); end
      checks++; if (o.reg_m !== e.reg_m) begin errors++; $display("FAIL %s reg_we cycles got %b want %b", e.name, o.reg_m, e.reg_m); end
      checks++; if (o.rw_bad !== 1'b0) begin errors++; $display("FAIL %s mem_rw wrong during mem_req got bad=%b want 0", e.name, o.rw_bad); end
      checks++; if (o.pc_after !== e.pc_after) begin errors++; $display("FAIL %s pc got %h want %h", e.name, o.pc_after, e.pc_after); end
      checks++; if (o.ret_after !== e.ret_after) begin errors++; $display("FAIL %s retired got %0d want %0d", e.name, o.ret_after, e.ret_after); end
      $display("%s: mem_req=%b reg_we=%b pc=%h retired=%0d", o.name, o.req_m, o.reg_m, o.pc_after, o.ret_after);
    end
  endtask

  task automatic test_cond_all();
    rec_t o, e;
    logic [31:0] w;
    int bad;
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        w = {c[3:0], 4'h5, 1'($urandom_range(0, 1)), 23'h0};
        run_instr("cond_all", w, f[3:0], 0, o);
        e = exp_q.pop_front();
        checks++; if (o.reg_m !== e.reg_m) begin errors++; bad++; $display("FAIL cond=%0d flags=%b reg_we cycles got %b want %b", c, f[3:0], o.reg_m, e.reg_m); end
        checks++; if (o.flag_m !== e.flag_m) begin errors++; bad++; $display("FAIL cond=%0d flags=%b flag_we cycles got %b want %b", c, f[3:0], o.flag_m, e.flag_m); end
        checks++; if (o.pc_after !== e.pc_after) begin errors++; bad++; $display("FAIL cond=%0d flags=%b pc got %h want %h", c, f[3:0], o.pc_after, e.pc_after); end
        checks++; if (o.ret_after !== e.ret_after) begin errors++; bad++; $display("FAIL cond=%0d flags=%b retired got %0d want %0d", c, f[3:0], o.ret_after, e.ret_after); end
      end
      $display("cond_all: cond=%0d swept 16 flag values, pc=%h retired=%0d", c, exp_pc, exp_ret);
    end
  endtask

  task automatic test_reset_mid_mem();
    ram[exp_pc] = 32'hEA00_0000;  // AL LDR
    flags = 4'b0000;
    for (int c = 1; c <= 4; c++) begin
      mem_ready = (c < 4);
      #1;
      if (c == 4) begin
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mem mem_req in MEM got %b want 1", mem_req); end
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if ({mem_req, reg_we} !== 2'b10) begin errors++; $display("FAIL rst_mem 2nd MEM cycle {mem_req,reg_we} got %b want 10", {mem_req, reg_we}); end
    @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem mem_req after reset got %b want 0", mem_req); end
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL rst_mem reg_we after reset got %b want 0", reg_we); end
    checks++; if (fetch_addr !== 8'h00) begin errors++; $display("FAIL rst_mem pc got %h want 00", fetch_addr); end
    checks++; if (retired !== 16'h0) begin errors++; $display("FAIL rst_mem retired got %0d want 0", retired); end
    reset = 1'b0;
    exp_pc = 8'h00; exp_ret = 16'h0;
    $display("rst_mem: mem_req=%b pc=%h retired=%0d", mem_req, fetch_addr, retired);
  endtask

  task automatic test_halt();
    rec_t o, e;
    run_instr("halt", 32'hEF00_0000, 4'b0000, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.halted_after !== e.halted_after) begin errors++; $display("FAIL %s halted got %b want %b", e.name, o.halted_after, e.halted_after); end
    checks++; if (o.pc_after !== e.pc_after) begin errors++; $display("FAIL %s pc got %h want %h", e.name, o.pc_after, e.pc_after); end
    checks++; if (o.ret_after !== e.ret_after) begin errors++; $display("FAIL %s retired got %0d want %0d", e.name, o.ret_after, e.ret_after); end
    checks++; if ((o.reg_m | o.flag_m | o.req_m) !== 32'h0) begin errors++; $display("FAIL %s strobes got %b want 0", e.name, o.reg_m | o.flag_m | o.req_m); end
    $display("%s: halted=%b pc=%h retired=%0d", o.name, o.halted_after, o.pc_after, o.ret_after);
    for (int i = 0; i < 20; i++) begin
      for (int a = 0; a < 256; a++) ram[a] = $urandom;
      flags = 4'($urandom_range(0, 15));
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (fetch_addr !== e.pc_after || halted !== 1'b1 || {reg_we, flag_we, mem_req} !== 3'b000 || retired !== e.ret_after) begin
        errors++;
        $display("FAIL halt_hold cycle %0d got addr=%h halted=%b strobes=%b retired=%0d want addr=%h halted=1 strobes=000 retired=%0d",
                 i, fetch_addr, halted, {reg_we, flag_we, mem_req}, retired, e.pc_after, e.ret_after);
      end
      @(negedge clk);
    end
    $display("halt_hold: 20 cycles, addr=%h halted=%b", fetch_addr, halted);
  endtask

  initial begin
    test_reset();
    test_dataproc();
    test_cond_eq();
    test_branch();
    test_pc_wrap();
    test_ldr_str();
    test_cond_all();
    test_reset_mid_mem();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
